// File: rtl/alu_pipe_if.sv
// Operand/result bundle between the datapath registers and alu_pipe.
// Carries the operation handshake, the registered results and an FSM debug tap.
interface alu_pipe_if #(
   parameter int WIDTH = 8
);
   // Handshake: an operation transfers on a rising clk edge where in_valid && in_ready.
   // in_valid without in_ready is dropped (not queued); out_valid is a one-cycle pulse
   // marking the cycle in which out/carry/mul_hi carry the result of a finished operation.
   logic [WIDTH-1:0] accum;
   logic [WIDTH-1:0] data;
   logic [3:0]       opcode;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             carry;
   logic [WIDTH-1:0] mul_hi;
   logic             zero;
   logic [1:0]       fsm_state;

   modport master (
      output accum, data, opcode, in_valid,
      input  in_ready, out, out_valid, carry, mul_hi, zero, fsm_state
   );

   modport slave (
      input  accum, data, opcode, in_valid,
      output in_ready, out, out_valid, carry, mul_hi, zero, fsm_state
   );
endinterface

// File: rtl/alu_pipe.sv
// Registered accumulator ALU with carry flag, valid/ready handshake and a
// multi-cycle shift-add unsigned multiply.
package typedefs;
   typedef enum logic [3:0] {
      OP_HLT = 4'd0,
      OP_SKZ = 4'd1,
      OP_ADD = 4'd2,
      OP_AND = 4'd3,
      OP_XOR = 4'd4,
      OP_LDA = 4'd5,
      OP_STO = 4'd6,
      OP_JMP = 4'd7,
      OP_ADC = 4'd8,
      OP_SUB = 4'd9,
      OP_SHL = 4'd10,
      OP_SHR = 4'd11,
      OP_MUL = 4'd12,
      OP_OR  = 4'd13,
      OP_NOT = 4'd14,
      OP_RSV = 4'd15
   } opcode4_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL_BUSY = 2'd1
   } alu_state_t;
endpackage

module alu_pipe
   import typedefs::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic       clk,
   input  logic       rst_,
   alu_pipe_if.slave  bus
);

   alu_state_t         state;
   opcode4_t           op;
   logic               accept;

   logic [WIDTH-1:0]   out_q;
   logic               out_valid_q;
   logic               carry_q;
   logic [WIDTH-1:0]   mul_hi_q;

   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] prod;
   logic [CNT_W-1:0]   count;

   logic [WIDTH:0]     sum_ext;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_carry;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_next;

   assign op             = opcode4_t'(bus.opcode);
   assign bus.in_ready   = (state == ST_IDLE);
   assign accept         = bus.in_valid && bus.in_ready;

   assign bus.out        = out_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.carry      = carry_q;
   assign bus.mul_hi     = mul_hi_q;
   assign bus.fsm_state  = state;
   assign bus.zero       = (bus.accum == '0);

   // Single-cycle result path; ops that do not write carry leave it as registered.
   always_comb begin
      sum_ext   = {1'b0, bus.accum} + {1'b0, bus.data}
                + {{WIDTH{1'b0}}, (op == OP_ADC) & carry_q};
      alu_res   = bus.accum;
      alu_carry = carry_q;
      case (op)
         OP_ADD, OP_ADC: begin
            alu_res   = sum_ext[WIDTH-1:0];
            alu_carry = sum_ext[WIDTH];
         end
         OP_AND: alu_res = bus.accum & bus.data;
         OP_XOR: alu_res = bus.accum ^ bus.data;
         OP_OR:  alu_res = bus.accum | bus.data;
         OP_LDA: alu_res = bus.data;
         OP_NOT: alu_res = ~bus.accum;
         OP_SUB: begin
            alu_res   = bus.accum - bus.data;
            alu_carry = (bus.accum < bus.data);
         end
         OP_SHL: {alu_carry, alu_res} = {bus.accum, 1'b0};
         OP_SHR: {alu_res, alu_carry} = {1'b0, bus.accum};
         default: begin
            alu_res   = bus.accum;
            alu_carry = carry_q;
         end
      endcase
   end

   // The multiplier rides in the low half of prod and is shifted out as the
   // partial product is shifted in, so the low half needs no separate clear.
   always_comb begin
      mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]}
                + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
      prod_next = {mul_sum, prod[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state       <= ST_IDLE;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         carry_q     <= 1'b0;
         mul_hi_q    <= '0;
         mcand       <= '0;
         prod        <= '0;
         count       <= '0;
      end else begin
         out_valid_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (op == OP_MUL) begin
                     state <= ST_MUL_BUSY;
                     mcand <= bus.accum;
                     prod  <= {{WIDTH{1'b0}}, bus.data};
                     count <= CNT_W'(WIDTH);
                  end else begin
                     out_q       <= alu_res;
                     carry_q     <= alu_carry;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            ST_MUL_BUSY: begin
               prod  <= prod_next;
               count <= count - 1'b1;
               // Last iteration: publish straight from prod_next so the result
               // appears on the same edge the counter reaches zero.
               if (count == CNT_W'(1)) begin
                  out_q       <= prod_next[WIDTH-1:0];
                  mul_hi_q    <= prod_next[2*WIDTH-1:WIDTH];
                  carry_q     <= |prod_next[2*WIDTH-1:WIDTH];
                  out_valid_q <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized bench for alu_pipe at WIDTH=8, plus WIDTH=16 MUL/ADD corners.
// Expected results come from an arithmetic reference model and a scoreboard queue.
module tb_alu_pipe;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_ = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   bit                  m_carry = 1'b0;
   longint unsigned     m_hi    = 0;
   logic [2*W:0]        exp_q[$];

   alu_pipe_if #(.WIDTH(W))  bus8 ();
   alu_pipe_if #(.WIDTH(16)) bus16 ();

   alu_pipe #(.WIDTH(W))  dut8  (.clk(clk), .rst_(rst_), .bus(bus8.slave));
   alu_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst_(rst_), .bus(bus16.slave));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain modular arithmetic on the operand values.
   function automatic void model(input int op, input longint unsigned a, input longint unsigned d,
                                 output longint unsigned r, output bit c,
                                 output longint unsigned h, output int lat);
      longint unsigned m = 64'd1 << W;
      longint unsigned s;
      r = a; c = m_carry; h = m_hi; lat = 0;
      case (op)
         2:  begin s = a + d; r = s % m; c = (s >= m); end
         3:  r = a & d;
         4:  r = a ^ d;
         5:  r = d;
         8:  begin s = a + d + (m_carry ? 1 : 0); r = s % m; c = (s >= m); end
         9:  begin r = (a + m - d) % m; c = (a < d); end
         10: begin r = (a * 2) % m; c = (a >= m / 2); end
         11: begin r = a / 2; c = (a % 2 == 1); end
         12: begin s = a * d; r = s % m; h = s / m; c = (h != 0); lat = W; end
         13: r = a | d;
         14: r = m - 1 - a;
         default: r = a;
      endcase
   endfunction

   task automatic run_op(input int op, input int a, input int d, input bit check_drop);
      longint unsigned r, h;
      bit c;
      int lat, seen;
      logic [2*W:0] e;
      model(op, a, d, r, c, h, lat);
      m_carry = c;
      m_hi    = h;
      exp_q.push_back({c, h[W-1:0], r[W-1:0]});
      bus8.accum    = a[W-1:0];
      bus8.data     = d[W-1:0];
      bus8.opcode   = op[3:0];
      bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      seen = -1;
      for (int k = 0; k <= W + 3 && seen < 0; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         if (bus8.out_valid === 1'b1) seen = k;
      end
      chk($sformatf("latency_op%0d", op), seen, lat);
      e = exp_q.pop_front();
      if (seen >= 0) begin
         chk($sformatf("out_op%0d_%0h_%0h", op, a, d), bus8.out, e[W-1:0]);
         chk($sformatf("carry_op%0d_%0h_%0h", op, a, d), bus8.carry, e[2*W]);
         chk($sformatf("mul_hi_op%0d", op), bus8.mul_hi, e[2*W-1:W]);
      end
      if (check_drop) begin
         @(posedge clk); #1;
         chk("out_valid_drop", bus8.out_valid, 1'b0);
      end
   endtask

   initial begin
      int seen, pulses;
      logic [7:0] legacy_exp [8];
      legacy_exp = '{8'hDA, 8'hDA, 8'h11, 8'h12, 8'hED, 8'h37, 8'hDA, 8'hDA};

      bus8.accum = '0; bus8.data = '0; bus8.opcode = '0; bus8.in_valid = 1'b0;
      bus16.accum = '0; bus16.data = '0; bus16.opcode = '0; bus16.in_valid = 1'b0;

      // Clock/reset
      #2 rst_ = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", bus8.out, 8'h00);
      chk("rst_out_valid", bus8.out_valid, 1'b0);
      chk("rst_carry", bus8.carry, 1'b0);
      chk("rst_mul_hi", bus8.mul_hi, 8'h00);
      @(negedge clk) rst_ = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", bus8.in_ready, 1'b1);

      // ADD with carry out, then ADC consuming it
      run_op(2, 'hDA, 'h37, 1'b1);
      run_op(8, 'h01, 'h01, 1'b1);

      // Legacy opcode sweep
      for (int op = 0; op < 8; op++) begin
         run_op(op, 'hDA, 'h37, 1'b0);
         chk($sformatf("legacy_op%0d", op), bus8.out, legacy_exp[op]);
      end

      // zero is combinational on accum
      bus8.accum = 8'h00; #1;
      chk("zero_set", bus8.zero, 1'b1);
      bus8.accum = 8'h40; #1;
      chk("zero_clear", bus8.zero, 1'b0);

      run_op(9,  'h10, 'h20, 1'b0);
      run_op(10, 'h81, 'h00, 1'b0);
      run_op(11, 'h01, 'h00, 1'b0);
      run_op(14, 'h0F, 'h00, 1'b0);
      run_op(15, 'h33, 'h44, 1'b1);

      // MUL 12*34 with an ADD offered while busy
      bus8.accum = 8'h12; bus8.data = 8'h34; bus8.opcode = 4'd12; bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      chk("mul_accept_ready_low", bus8.in_ready, 1'b0);
      for (int k = 1; k <= W; k++) begin
         if (k == 3) begin
            bus8.accum = 8'h01; bus8.data = 8'h01; bus8.opcode = 4'd2; bus8.in_valid = 1'b1;
         end
         if (k == 4) bus8.in_valid = 1'b0;
         @(posedge clk); #1;
         if (k < W) begin
            chk($sformatf("mul_busy_ready_k%0d", k), bus8.in_ready, 1'b0);
            chk($sformatf("mul_busy_valid_k%0d", k), bus8.out_valid, 1'b0);
         end
      end
      chk("mul_done_valid", bus8.out_valid, 1'b1);
      chk("mul_done_ready", bus8.in_ready, 1'b1);
      chk("mul_out", bus8.out, 8'hA8);
      chk("mul_hi", bus8.mul_hi, 8'h03);
      chk("mul_carry", bus8.carry, 1'b1);
      m_carry = 1'b1; m_hi = 'h03;
      // Back-to-back MUL offered in the out_valid cycle
      run_op(12, 'h03, 'h05, 1'b1);
      run_op(12, 'hFF, 'hFF, 1'b0);

      // Reset during a MUL
      bus8.accum = 8'h12; bus8.data = 8'h34; bus8.opcode = 4'd12; bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_ = 1'b0;
      #1;
      chk("midrst_out", bus8.out, 8'h00);
      chk("midrst_carry", bus8.carry, 1'b0);
      chk("midrst_mul_hi", bus8.mul_hi, 8'h00);
      chk("midrst_out_valid", bus8.out_valid, 1'b0);
      m_carry = 1'b0; m_hi = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_ = 1'b1;
      @(posedge clk); #1;
      chk("midrst_in_ready", bus8.in_ready, 1'b1);
      pulses = 0;
      for (int k = 0; k < W + 4; k++) begin
         @(posedge clk); #1;
         if (bus8.out_valid === 1'b1) pulses++;
      end
      chk("midrst_no_late_valid", pulses, 0);

      // Randomized operations against the model
      for (int i = 0; i < 60; i++) begin
         run_op($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
                ($urandom_range(0, 3) == 0));
      end

      // WIDTH=16 corners
      bus16.accum = 16'hFFFF; bus16.data = 16'hFFFF; bus16.opcode = 4'd12; bus16.in_valid = 1'b1;
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      seen = -1;
      for (int k = 1; k <= 20 && seen < 0; k++) begin
         @(posedge clk); #1;
         if (bus16.out_valid === 1'b1) seen = k;
      end
      chk("w16_mul_latency", seen, 16);
      chk("w16_mul_out", bus16.out, 16'h0001);
      chk("w16_mul_hi", bus16.mul_hi, 16'hFFFE);
      chk("w16_mul_carry", bus16.carry, 1'b1);
      bus16.accum = 16'hFFFF; bus16.data = 16'h0001; bus16.opcode = 4'd2; bus16.in_valid = 1'b1;
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      chk("w16_add_valid", bus16.out_valid, 1'b1);
      chk("w16_add_out", bus16.out, 16'h0000);
      chk("w16_add_carry", bus16.carry, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
